// File: rtl/banco_pkg.sv
// Shared constants and types for the register-bank write-back front end.
package banco_pkg;

  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 32;

  typedef struct packed {
    logic [AW-1:0] dir;
    logic [DW-1:0] dato;
  } wr_req_t;

  // One-hot decode of a register address.
  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] d);
    onehot = NREG'(1) << d;
  endfunction

endpackage

// File: rtl/fifo2.sv
// Two-entry write-request FIFO with occupancy count, synchronous flush and
// a mask of the registers targeted by the entries it currently holds.
module fifo2
  import banco_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            push_i,
  input  wr_req_t         din_i,
  input  logic            pop_i,
  output wr_req_t         head_o,
  output logic [1:0]      count_o,
  output logic [NREG-1:0] occ_o
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  wr_req_t    mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign do_push = push_i && (count_q < FULL);
  assign do_pop  = pop_i && (count_q != 2'd0);

  // Next pointer and count values for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // Control state; flush wins over any concurrent push or pop.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; a write during flush lands in a slot that is marked empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Registers targeted by valid entries only.
  always_comb begin
    occ_o = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if ((count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i))))
        occ_o = occ_o | onehot(mem_q[i].dir);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/banco_escritura.sv
// Write-back front end: buffers scalar and vector write requests, drives the
// bank's C and V write ports, arbitrates same-register collisions with a
// toggling priority and exports the pending-write mask for hazard stalls.
module banco_escritura
  import banco_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [AW-1:0]   s_dir,
  input  logic [DW-1:0]   s_dato,
  input  logic            v_valid,
  output logic            v_ready,
  input  logic [AW-1:0]   v_dir,
  input  logic [DW-1:0]   v_dato,
  input  logic            stall,
  input  logic            flush,
  output logic            WE_C,
  output logic [AW-1:0]   DirC,
  output logic [DW-1:0]   DinC,
  output logic            WE_V,
  output logic [AW-1:0]   DirV,
  output logic [DW-1:0]   DinV,
  output logic [NREG-1:0] busy_mask
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  wr_req_t         s_head, v_head;
  logic [1:0]      s_count, v_count;
  logic [NREG-1:0] s_occ, v_occ;
  logic            s_push, v_push;
  logic            s_has, v_has, can_issue, coll;
  logic            s_pop, v_pop;

  logic            we_c_q, we_v_q, prio_v_q, prio_v_d;
  logic [AW-1:0]   dir_c_q, dir_v_q;
  logic [DW-1:0]   din_c_q, din_v_q;

  assign s_ready = (s_count < FULL);
  assign v_ready = (v_count < FULL);
  assign s_push  = s_valid && s_ready;
  assign v_push  = v_valid && v_ready;

  fifo2 #(.DEPTH(DEPTH)) u_fifo_s (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (s_push),
    .din_i   ('{dir: s_dir, dato: s_dato}),
    .pop_i   (s_pop),
    .head_o  (s_head),
    .count_o (s_count),
    .occ_o   (s_occ)
  );

  fifo2 #(.DEPTH(DEPTH)) u_fifo_v (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (v_push),
    .din_i   ('{dir: v_dir, dato: v_dato}),
    .pop_i   (v_pop),
    .head_o  (v_head),
    .count_o (v_count),
    .occ_o   (v_occ)
  );

  // Issue selection: on a same-register collision only the prioritised port pops.
  always_comb begin
    s_has     = (s_count != 2'd0);
    v_has     = (v_count != 2'd0);
    can_issue = !stall && !flush;
    coll      = s_has && v_has && (s_head.dir == v_head.dir);
    s_pop     = can_issue && s_has && (!coll || !prio_v_q);
    v_pop     = can_issue && v_has && (!coll || prio_v_q);
    prio_v_d  = (can_issue && coll) ? !prio_v_q : prio_v_q;
  end

  // Port output registers and collision priority; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_c_q   <= 1'b0;
      we_v_q   <= 1'b0;
      dir_c_q  <= '0;
      din_c_q  <= '0;
      dir_v_q  <= '0;
      din_v_q  <= '0;
      prio_v_q <= 1'b0;
    end else if (flush) begin
      we_c_q   <= 1'b0;
      we_v_q   <= 1'b0;
      prio_v_q <= 1'b0;
    end else begin
      we_c_q   <= s_pop;
      we_v_q   <= v_pop;
      prio_v_q <= prio_v_d;
      if (s_pop) begin
        dir_c_q <= s_head.dir;
        din_c_q <= s_head.dato;
      end
      if (v_pop) begin
        dir_v_q <= v_head.dir;
        din_v_q <= v_head.dato;
      end
    end
  end

  assign WE_C = we_c_q;
  assign DirC = dir_c_q;
  assign DinC = din_c_q;
  assign WE_V = we_v_q;
  assign DirV = dir_v_q;
  assign DinV = din_v_q;

  assign busy_mask = s_occ | v_occ
                   | (we_c_q ? onehot(dir_c_q) : '0)
                   | (we_v_q ? onehot(dir_v_q) : '0);

endmodule

// File: tb/tb_banco_escritura.sv
// Directed, table-driven bench for banco_escritura.
module tb_banco_escritura;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, v_valid, stall, flush;
  logic        s_ready, v_ready;
  logic [3:0]  s_dir, v_dir;
  logic [31:0] s_dato, v_dato;
  logic        WE_C, WE_V;
  logic [3:0]  DirC, DirV;
  logic [31:0] DinC, DinV;
  logic [15:0] busy_mask;

  int checks   = 0;
  int failures = 0;

  banco_escritura #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_dir     (s_dir),
    .s_dato    (s_dato),
    .v_valid   (v_valid),
    .v_ready   (v_ready),
    .v_dir     (v_dir),
    .v_dato    (v_dato),
    .stall     (stall),
    .flush     (flush),
    .WE_C      (WE_C),
    .DirC      (DirC),
    .DinC      (DinC),
    .WE_V      (WE_V),
    .DirV      (DirV),
    .DinV      (DinV),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sv;
    logic [3:0]  sd;
    logic [31:0] sdat;
    logic        vv;
    logic [3:0]  vd;
    logic [31:0] vdat;
    logic        st;
    logic        fl;
    logic        wec;
    logic [3:0]  dirc;
    logic [31:0] dinc;
    logic        wev;
    logic [3:0]  dirv;
    logic [31:0] dinv;
    logic [15:0] busy;
    logic        sr;
    logic        vr;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mkv(
    input logic sv, input logic [3:0] sd, input logic [31:0] sdat,
    input logic vv, input logic [3:0] vd, input logic [31:0] vdat,
    input logic st, input logic fl,
    input logic wec, input logic [3:0] dirc, input logic [31:0] dinc,
    input logic wev, input logic [3:0] dirv, input logic [31:0] dinv,
    input logic [15:0] busy, input logic sr, input logic vr);
    vec_t r;
    r.sv = sv; r.sd = sd; r.sdat = sdat;
    r.vv = vv; r.vd = vd; r.vdat = vdat;
    r.st = st; r.fl = fl;
    r.wec = wec; r.dirc = dirc; r.dinc = dinc;
    r.wev = wev; r.dirv = dirv; r.dinv = dinv;
    r.busy = busy; r.sr = sr; r.vr = vr;
    return r;
  endfunction

  function automatic logic [15:0] oh(input int d);
    return 16'(1) << (d & 15);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic wec, input logic [3:0] dirc,
                         input logic [31:0] dinc, input logic wev, input logic [3:0] dirv,
                         input logic [31:0] dinv, input logic [15:0] busy,
                         input logic sr, input logic vr);
    chk({tag, ".WE_C"}, 32'(WE_C), 32'(wec));
    chk({tag, ".DirC"}, 32'(DirC), 32'(dirc));
    chk({tag, ".DinC"}, DinC, dinc);
    chk({tag, ".WE_V"}, 32'(WE_V), 32'(wev));
    chk({tag, ".DirV"}, 32'(DirV), 32'(dirv));
    chk({tag, ".DinV"}, DinV, dinv);
    chk({tag, ".busy"}, 32'(busy_mask), 32'(busy));
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(sr));
    chk({tag, ".v_ready"}, 32'(v_ready), 32'(vr));
  endtask

  task automatic idle_inputs();
    s_valid = 1'b0; s_dir = '0; s_dato = '0;
    v_valid = 1'b0; v_dir = '0; v_dato = '0;
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    //            sv sd   sdat          vv vd   vdat          st fl  wec dc   dinc          wev dv   dinv          busy       sr vr
    tbl[0]  = mkv(1, 4'h3, 32'hDEADBEEF, 0, 4'h0, 32'h0,       0, 0,  0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       16'h0008,  1, 1);
    tbl[1]  = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  1, 4'h3, 32'hDEADBEEF, 0, 4'h0, 32'h0,       16'h0008,  1, 1);
    tbl[2]  = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  0, 4'h3, 32'hDEADBEEF, 0, 4'h0, 32'h0,       16'h0000,  1, 1);
    tbl[3]  = mkv(1, 4'h5, 32'h11,       1, 4'h5, 32'h22,      0, 0,  0, 4'h3, 32'hDEADBEEF, 0, 4'h0, 32'h0,       16'h0020,  1, 1);
    tbl[4]  = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  1, 4'h5, 32'h11,       0, 4'h0, 32'h0,       16'h0020,  1, 1);
    tbl[5]  = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  0, 4'h5, 32'h11,       1, 4'h5, 32'h22,      16'h0020,  1, 1);
    tbl[6]  = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  0, 4'h5, 32'h11,       0, 4'h5, 32'h22,      16'h0000,  1, 1);
    tbl[7]  = mkv(1, 4'h7, 32'h33,       1, 4'h7, 32'h44,      0, 0,  0, 4'h5, 32'h11,       0, 4'h5, 32'h22,      16'h0080,  1, 1);
    tbl[8]  = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  0, 4'h5, 32'h11,       1, 4'h7, 32'h44,      16'h0080,  1, 1);
    tbl[9]  = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  1, 4'h7, 32'h33,       0, 4'h7, 32'h44,      16'h0080,  1, 1);
    tbl[10] = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  0, 4'h7, 32'h33,       0, 4'h7, 32'h44,      16'h0000,  1, 1);
    tbl[11] = mkv(1, 4'h1, 32'hA1,       0, 4'h0, 32'h0,       1, 0,  0, 4'h7, 32'h33,       0, 4'h7, 32'h44,      16'h0002,  1, 1);
    tbl[12] = mkv(1, 4'h2, 32'hA2,       0, 4'h0, 32'h0,       1, 0,  0, 4'h7, 32'h33,       0, 4'h7, 32'h44,      16'h0006,  0, 1);
    tbl[13] = mkv(1, 4'h4, 32'hA4,       0, 4'h0, 32'h0,       1, 0,  0, 4'h7, 32'h33,       0, 4'h7, 32'h44,      16'h0006,  0, 1);
    tbl[14] = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  1, 4'h1, 32'hA1,       0, 4'h7, 32'h44,      16'h0006,  1, 1);
    tbl[15] = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  1, 4'h2, 32'hA2,       0, 4'h7, 32'h44,      16'h0004,  1, 1);
    tbl[16] = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  0, 4'h2, 32'hA2,       0, 4'h7, 32'h44,      16'h0000,  1, 1);
    tbl[17] = mkv(1, 4'h8, 32'hB8,       1, 4'h9, 32'hC9,      1, 0,  0, 4'h2, 32'hA2,       0, 4'h7, 32'h44,      16'h0300,  1, 1);
    tbl[18] = mkv(1, 4'hA, 32'hBA,       1, 4'hB, 32'hCB,      1, 0,  0, 4'h2, 32'hA2,       0, 4'h7, 32'h44,      16'h0F00,  0, 0);
    tbl[19] = mkv(1, 4'hC, 32'hDD,       1, 4'hD, 32'hEE,      0, 1,  0, 4'h2, 32'hA2,       0, 4'h7, 32'h44,      16'h0000,  1, 1);
    tbl[20] = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  0, 4'h2, 32'hA2,       0, 4'h7, 32'h44,      16'h0000,  1, 1);
    tbl[21] = mkv(1, 4'hC, 32'hDD,       1, 4'hD, 32'hEE,      1, 1,  0, 4'h2, 32'hA2,       0, 4'h7, 32'h44,      16'h0000,  1, 1);
    tbl[22] = mkv(0, 4'h0, 32'h0,        0, 4'h0, 32'h0,       0, 0,  0, 4'h2, 32'hA2,       0, 4'h7, 32'h44,      16'h0000,  1, 1);

    // Reset held for two edges while a scalar request is presented.
    idle_inputs();
    rst_n = 1'b0;
    s_valid = 1'b1; s_dir = 4'h6; s_dato = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_all($sformatf("reset%0d", i), 0, 4'h0, 32'h0, 0, 4'h0, 32'h0, 16'h0000, 1, 1);
    end
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    chk_all("post_reset", 0, 4'h0, 32'h0, 0, 4'h0, 32'h0, 16'h0000, 1, 1);

    // Table: single write, collisions with toggling priority, backpressure, flush.
    for (int i = 0; i < 23; i++) begin
      s_valid = tbl[i].sv; s_dir = tbl[i].sd; s_dato = tbl[i].sdat;
      v_valid = tbl[i].vv; v_dir = tbl[i].vd; v_dato = tbl[i].vdat;
      stall = tbl[i].st; flush = tbl[i].fl;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].wec, tbl[i].dirc, tbl[i].dinc,
              tbl[i].wev, tbl[i].dirv, tbl[i].dinv, tbl[i].busy, tbl[i].sr, tbl[i].vr);
    end

    // Parallel streams on disjoint registers for 16 cycles, then drain.
    for (int i = 0; i <= 16; i++) begin
      logic [15:0] eb;
      idle_inputs();
      if (i < 16) begin
        s_valid = 1'b1; s_dir = 4'(i);     s_dato = 32'h1000 + 32'(i);
        v_valid = 1'b1; v_dir = 4'(i + 8); v_dato = 32'h2000 + 32'(i);
      end
      @(posedge clk); #1;
      eb = (i < 16) ? (oh(i) | oh(i + 8)) : 16'h0000;
      if (i == 0) begin
        chk_all("par0", 0, 4'h2, 32'hA2, 0, 4'h7, 32'h44, eb, 1, 1);
      end else begin
        eb = eb | oh(i - 1) | oh(i + 7);
        chk_all($sformatf("par%0d", i), 1, 4'(i - 1), 32'h1000 + 32'(i - 1),
                1, 4'(i + 7), 32'h2000 + 32'(i - 1), eb, 1, 1);
      end
    end
    idle_inputs();
    @(posedge clk); #1;
    chk_all("par_end", 0, 4'hF, 32'h100F, 0, 4'h7, 32'h200F, 16'h0000, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/banco_escritura.md
# banco_escritura

Write-back front end for the 16×32 register bank. Accepts write requests from two producers, the scalar ALU result path and the vector/pixel load unit, each through a valid/ready handshake. Buffers each stream in a 2-entry FIFO and drives the bank's two write ports: C from the scalar stream, V from the vector stream. Resolves same-register collisions between the ports deterministically and exports a pending-write mask so decode can stall on read-after-write hazards.

## Interface
Parameters:
- DEPTH, 2, entries per source FIFO (fixed at 2; pointers are 1 bit)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- s_valid  in  1  scalar request valid
- s_ready  out  1  scalar FIFO can accept
- s_dir  in  4  scalar destination register
- s_dato  in  32  scalar write data
- v_valid  in  1  vector request valid
- v_ready  out  1  vector FIFO can accept
- v_dir  in  4  vector destination register
- v_dato  in  32  vector write data
- stall  in  1  freeze issue (bank busy with filter readout); FIFOs still accept
- flush  in  1  synchronous discard of all queued and issuing writes
- WE_C  out  1  bank port C write enable, active-high
- DirC  out  4  bank port C address
- DinC  out  32  bank port C data
- WE_V  out  1  bank port V write enable, active-high
- DirV  out  4  bank port V address
- DinV  out  32  bank port V data
- busy_mask  out  16  bit i = 1 while any queued or issuing write targets register i

## Operation
- Handshake: transfer on an edge where valid & ready. s_ready = (s_count < 2); v_ready likewise. Both come from registered count only, with no same-cycle pass-through when full.
- Issue, each cycle, with stall = 0 and flush = 0:
  - A non-empty head is popped into its port's output register.
  - Only one head present: only that port issues.
- Collision: both heads present with equal dir.
  - Only one port issues that cycle; the other head stays.
  - Priority register prio_v selects the winner: 0 means scalar wins, 1 means vector wins.
  - prio_v toggles after every collision issue and is unchanged otherwise. This guarantees no starvation.
- The two ports never write the same register in the same cycle.
- Non-issuing cycles: WE_C/WE_V drop to 0. DirC/DinC/DirV/DinV hold their last values.
- stall = 1:
  - No pops; WE_C = WE_V = 0 on the next cycle.
  - FIFOs keep accepting until full.
- flush = 1, or rst_n = 0:
  - Counts and pointers go to 0; WE_C = WE_V = 0; prio_v = 0.
  - Requests presented in that same cycle are dropped.
  - flush has priority over stall and over a concurrent push.
- busy_mask = OR of one-hot(dir) over valid FIFO entries of both sources, plus one-hot of each output register whose WE is set. Combinational from registered state.

## Timing
- Reset values:
  - WE_C = WE_V = 0.
  - DirC = DirV = 0; DinC = DinV = 0.
  - busy_mask = 0.
  - s_ready = v_ready = 1.
- Latency, empty FIFO, no stall or collision:
  - Request accepted at edge k.
  - WE/Dir/Din registered at edge k+1 and valid during cycle k+1..k+2.
  - Bank commits at edge k+2.
- Throughput: 1 write per port per cycle. A collision costs the loser 1 cycle.
- Simultaneous push and pop on the same FIFO: count unchanged. Data ordering is strict FIFO per source.
- Ordering across sources is defined only through collision priority.
- busy_mask bit for a write: set from edge k to edge k+2.

## Structure
- Shared package banco_pkg:
  - constants NREG = 16, AW = 4, DW = 32.
  - struct wr_req_t {dir, dato}.
- Sub-module fifo2: 2-entry FIFO with count, push/pop, flush. Instantiated once per source.
- Top holds the collision/priority logic, the output registers and busy_mask.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with s_valid = 1 -> all outputs zero, ready = 1, nothing queued after release.
- Single write: s_dir = 3, s_dato = 0xDEADBEEF at edge k -> WE_C = 1, DirC = 3, DinC = 0xDEADBEEF for exactly cycle k+1; busy_mask = 0x0008 over k..k+2.
- Collision: s (dir 5, 0x11) and v (dir 5, 0x22) accepted at the same edge k -> cycle k+1: only WE_C; cycle k+2: only WE_V. A second collision then issues V first, confirming prio_v toggles.
- Backpressure: stall = 1, push 3 scalar requests -> 2 accepted, s_ready = 0 after the 2nd. Release stall -> 2 consecutive WE_C pulses in FIFO order.
- Parallel streams: disjoint dirs on s and v every cycle for 16 cycles -> WE_C and WE_V high every cycle after the first, zero stalls, ready = 1 throughout.
- Flush mid-operation: 2 entries queued per source, flush = 1 -> next cycle WE = 0, busy_mask = 0, ready = 1; no queued write reaches the bank.
